rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-way one-hot select resource, such as the 3-to-8 decoded enable bus, among 8 requesters.
- Picks a winner index, registers it, and drives the decoded one-hot grant.
- Enforces a bounded hold time so a requester that keeps its request asserted cannot starve the others.
- Sits between requester logic and the shared datapath select lines.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per holder while others are waiting. 0 disables preemption.
- HOLD_W, 5: width of the hold counter. Must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request vector, bit i = requester i; level-sensitive
- gnt  output  8  registered one-hot grant, or all zero
- gnt_idx  output  3  binary index of current/last grantee
- gnt_valid  output  1  high while gnt is nonzero
- preempt  output  1  one-cycle pulse on the cycle a grant is forcibly moved

Behaviour:
- Reset (async, rst_n=0):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, preempt=0.
  - Internal: priority pointer ptr=0, hold_cnt=0, state IDLE.
  - Takes effect immediately, including mid-grant. The first grant after reset is evaluated at the first rising edge with rst_n=1.
- All outputs are registered. No combinational path from req to any output.
- Invariants:
  - gnt == (8'h01 << gnt_idx) whenever gnt_valid=1.
  - gnt == 0 whenever gnt_valid=0.
  - gnt is never more than one-hot.
- Search function: first i, scanning ptr, ptr+1, ..., wrapping 7->0, such that req[i]=1 and i is not excluded.
- State IDLE:
  - req==0 at an edge: stay IDLE, outputs unchanged (gnt_idx keeps its last value).
  - req!=0 at an edge: grant the search winner at that edge. gnt_valid=1, hold_cnt=0, state GRANT.
  - Latency: request sampled at edge k, grant visible after edge k (1 cycle).
- State GRANT (holder h = gnt_idx), evaluated at each edge:
  - Release (req[h]=0):
    - ptr = h+1 mod 8.
    - If any other req bit is set: grant the search winner (from the new ptr) at the same edge with no bubble; hold_cnt=0.
    - Otherwise: gnt=0, gnt_valid=0, state IDLE.
  - Preempt (MAX_HOLD!=0, req[h]=1, hold_cnt==MAX_HOLD-1, and (req & ~gnt)!=0):
    - ptr = h+1 mod 8; grant the search winner with h excluded; hold_cnt=0.
    - preempt=1 for exactly that cycle.
  - Hold (otherwise): keep grant. hold_cnt increments, saturating at MAX_HOLD-1 (or at all-ones when MAX_HOLD=0).
- Holder budget: a holder gets exactly MAX_HOLD consecutive grant cycles when contended. An uncontended holder keeps the grant indefinitely.
- A new request appearing on the same edge as a release or preempt is eligible in that edge's search.
- ptr changes only on release or preempt, never on a grant from IDLE.
- preempt is 0 in every cycle except a forced handover.

Test Plan:
- Reset then req=8'h01 → one cycle later gnt=8'h01, gnt_idx=0, gnt_valid=1. Drop req → next cycle gnt=0, gnt_valid=0.
- Rotation: ptr=0, req=8'h0A held constantly, each holder drops its req after 2 cycles then reasserts → grants alternate gnt_idx 1,3,1,3 with no idle cycle between them.
- Wrap: holder 7 releases while req=8'h81 → next grant is index 0, not 7. gnt=8'h01.
- Preempt: MAX_HOLD=4, req=8'h05 held constantly → idx 0 for 4 cycles, then idx 2 with preempt=1 for one cycle, idx 2 for 4 cycles, then idx 0. Sole requester 8'h04 held 20 cycles → no preempt, grant kept.
- Async reset mid-grant: rst_n low between edges while gnt=8'h10 → gnt=0 and gnt_valid=0 immediately. After release with req=8'h30, first grant is index 4 (ptr back to 0).
- Random req for 10k cycles → one-hot/zero invariant holds, gnt==1<<gnt_idx whenever valid, and each waiting requester is granted within 7*MAX_HOLD+8 cycles.

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter for 8 requesters with a registered one-hot grant.
// A holder that is contended is moved on after MAX_HOLD consecutive grant cycles.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam logic [HOLD_W-1:0] HOLD_SAT =
        (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [2:0]        idx_q, idx_d;
    logic              valid_q, valid_d;
    logic              pre_q, pre_d;
    logic [7:0]        gnt_q, gnt_d;
    logic [7:0]        others;

    // Rotate so that index p sits at bit 0, then take the lowest set bit.
    function automatic logic [2:0] pick(input logic [7:0] m, input logic [2:0] p);
        logic [15:0] dbl;
        logic [7:0]  rot;
        logic [2:0]  w;
        dbl = {m, m} >> p;
        rot = dbl[7:0];
        w   = p;
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) w = p + 3'(k);
        end
        return w;
    endfunction

    assign others = req & ~(8'b1 << idx_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        pre_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = pick(req, ptr_q);
                    valid_d = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req[idx_q]) begin
                    ptr_d = idx_q + 3'd1;
                    if (|others) begin
                        idx_d  = pick(others, idx_q + 3'd1);
                        hold_d = '0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_q == HOLD_SAT && |others) begin
                    ptr_d  = idx_q + 3'd1;
                    idx_d  = pick(others, idx_q + 3'd1);
                    hold_d = '0;
                    pre_d  = 1'b1;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = valid_d ? (8'b1 << idx_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pre_q   <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pre_q   <= pre_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = pre_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed vectors plus a random soak, checked against
// a behavioural round-robin model every cycle.
module tb_rr_arbiter8;

    localparam int MAXH  = 4;
    localparam int BOUND = 7 * MAXH + 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 #(.MAX_HOLD(MAXH), .HOLD_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    // Model: grant tracked as (valid, index), held = grant cycles so far.
    bit m_valid = 0;
    int m_idx = 0;
    int m_ptr = 0;
    int m_held = 0;
    bit m_pre = 0;

    function automatic int search(input logic [7:0] r, input int p, input int ex);
        for (int k = 0; k < 8; k++) begin
            int j;
            j = (p + k) % 8;
            if (r[j] && j != ex) return j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_pre = 0;
        end else begin
            logic [7:0] r;
            logic [7:0] hm;
            r = req;
            m_pre = 0;
            if (!m_valid) begin
                if (r != 0) begin
                    m_idx = search(r, m_ptr, -1);
                    m_valid = 1;
                    m_held = 1;
                end
            end else if (!r[m_idx]) begin
                m_ptr = (m_idx + 1) % 8;
                if (r != 0) begin
                    m_idx = search(r, m_ptr, -1);
                    m_held = 1;
                end else begin
                    m_valid = 0;
                end
            end else begin
                hm = 8'h01 << m_idx;
                if (m_held >= MAXH && (r & ~hm) != 0) begin
                    m_ptr = (m_idx + 1) % 8;
                    m_idx = search(r, m_ptr, m_idx);
                    m_held = 1;
                    m_pre = 1;
                end else begin
                    m_held++;
                end
            end
        end
    end

    int waitc [8];

    always @(negedge clk) begin
        logic [7:0] eg;
        bit starve;
        eg = m_valid ? (8'h01 << m_idx) : 8'h00;
        checks++;
        if (gnt !== eg || gnt_valid !== m_valid || preempt !== m_pre ||
            gnt_idx !== 3'(m_idx)) begin
            errors++;
            $display("FAIL model t=%0t: gnt=%h idx=%0d valid=%0b pre=%0b, want gnt=%h idx=%0d valid=%0b pre=%0b",
                     $time, gnt, gnt_idx, gnt_valid, preempt, eg, m_idx, m_valid, m_pre);
        end
        checks++;
        if ((gnt_valid && gnt !== (8'h01 << gnt_idx)) || (!gnt_valid && gnt !== 8'h00)) begin
            errors++;
            $display("FAIL onehot t=%0t: gnt=%h idx=%0d valid=%0b", $time, gnt, gnt_idx, gnt_valid);
        end
        starve = 0;
        for (int i = 0; i < 8; i++) begin
            if (!rst_n || !req[i] || gnt[i]) waitc[i] = 0;
            else waitc[i]++;
            if (waitc[i] > BOUND) starve = 1;
        end
        checks++;
        if (starve) begin
            errors++;
            $display("FAIL starve t=%0t: req=%h gnt=%h waited more than %0d cycles",
                     $time, req, gnt, BOUND);
            for (int i = 0; i < 8; i++) waitc[i] = 0;
        end
    end

    task automatic chk(input string nm, input logic [7:0] g, input logic [2:0] i,
                       input logic v, input logic p);
        checks++;
        if (gnt !== g || gnt_idx !== i || gnt_valid !== v || preempt !== p) begin
            errors++;
            $display("FAIL %s: gnt=%h idx=%0d valid=%0b pre=%0b, want gnt=%h idx=%0d valid=%0b pre=%0b",
                     nm, gnt, gnt_idx, gnt_valid, preempt, g, i, v, p);
        end
    endtask

    // Present r for one rising edge, then return just after the following falling edge.
    task automatic cyc(input logic [7:0] r);
        req = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic vec(input string nm, input logic [7:0] r, input logic [7:0] g,
                       input logic [2:0] i, input logic v, input logic p);
        cyc(r);
        chk(nm, g, i, v, p);
    endtask

    task automatic do_reset();
        req = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        repeat (3) @(negedge clk);
        #1;
        chk("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        vec("first_grant", 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        vec("drop", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        vec("rot0", 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0);
        vec("rot1", 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0);
        vec("rot2", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        vec("rot3", 8'h0A, 8'h08, 3'd3, 1'b1, 1'b0);
        vec("rot4", 8'h02, 8'h02, 3'd1, 1'b1, 1'b0);
        vec("rot5", 8'h0A, 8'h02, 3'd1, 1'b1, 1'b0);
        vec("rot6", 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        vec("rot_idle", 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);

        vec("wrap0", 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
        vec("wrap1", 8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
        vec("wrap2", 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
        vec("wrap_idle", 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        do_reset();
        for (int k = 0; k < 4; k++) vec("pre_h0", 8'h05, 8'h01, 3'd0, 1'b1, 1'b0);
        vec("pre_to2", 8'h05, 8'h04, 3'd2, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) vec("pre_h2", 8'h05, 8'h04, 3'd2, 1'b1, 1'b0);
        vec("pre_to0", 8'h05, 8'h01, 3'd0, 1'b1, 1'b1);
        vec("pre_rel", 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) vec("sole", 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        vec("sole_idle", 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);

        vec("mid0", 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        vec("mid1", 8'h10, 8'h10, 3'd4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        req = 8'h30;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        vec("after_rst", 8'h30, 8'h10, 3'd4, 1'b1, 1'b0);

        r = 8'h00;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
            end
            cyc(r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
